// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: word width, RAM status codes and arbiter states.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // Status reported by the RAM model each cycle.
  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  // Arbiter grant state.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DGRANT = 2'b01,
    IGRANT = 2'b10
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between icache and dcache traffic. Data requests have
// priority, but an instruction request left waiting behind a data grant is
// served next. A grant is held until the RAM reports ACCESS or the granted
// requester withdraws. RAM outputs are combinational from the state and the
// granted side's inputs, so only the state and the ifirst flag are registered.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  // icache side
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  // dcache side
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  // RAM side
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  ramstate_t         ramstate
);

  arb_state_t state_q, state_d;
  // Set when a data grant completed while an instruction request was waiting.
  logic       ifirst_q, ifirst_d;

  logic dreq;
  logic ram_done;

  assign dreq     = dREN | dWEN;
  assign ram_done = (ramstate == ACCESS);

  // Read data is broadcast; each requester samples only while its wait is low.
  assign iload = ramload;
  assign dload = ramload;

  // Next-state selection and combinational RAM/wait outputs.
  always_comb begin
    state_d  = state_q;
    ifirst_d = ifirst_q;
    iwait    = 1'b1;
    dwait    = 1'b1;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;

    case (state_q)
      IDLE: begin
        if (ifirst_q && iREN) begin
          state_d = IGRANT;
        end else if (dreq) begin
          state_d = DGRANT;
        end else if (iREN) begin
          state_d = IGRANT;
        end
      end

      DGRANT: begin
        if (!dreq) begin
          // Requester withdrew: drop strobes now, no completion.
          state_d = IDLE;
        end else begin
          ramaddr = daddr;
          if (dWEN) begin
            ramWEN   = 1'b1;
            ramstore = dstore;
          end else begin
            ramREN = 1'b1;
          end
          if (ram_done) begin
            dwait   = 1'b0;
            state_d = IDLE;
            if (iREN) begin
              ifirst_d = 1'b1;
            end
          end
        end
      end

      IGRANT: begin
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ram_done) begin
            iwait    = 1'b0;
            state_d  = IDLE;
            ifirst_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Grant state and instruction-priority flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      ifirst_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ifirst_q <= ifirst_d;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios followed by random traffic, all
// checked against a transaction-level model of who owns the RAM port.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int unsigned W = 32;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         iREN, dREN, dWEN;
  logic [W-1:0] iaddr, daddr, dstore, ramload;
  logic         iwait, dwait, ramREN, ramWEN;
  logic [W-1:0] iload, dload, ramaddr, ramstore;
  ramstate_t    ramstate;

  int total = 0;
  int bad   = 0;

  // Model: owner 0 = nobody, 1 = dcache, 2 = icache; iowed = icache goes next.
  int owner;
  bit iowed;

  memory_arbiter #(.WORD_W(W)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output with what the owner model says the port should show.
  task automatic check_outputs(input string tag);
    logic         e_ren, e_wen, e_iw, e_dw;
    logic [W-1:0] e_addr, e_store;
    e_ren = 0; e_wen = 0; e_iw = 1; e_dw = 1; e_addr = '0; e_store = '0;
    if (owner == 1 && (dREN || dWEN)) begin
      e_addr = daddr;
      if (dWEN) begin
        e_wen   = 1;
        e_store = dstore;
      end else begin
        e_ren = 1;
      end
      if (ramstate == ACCESS) e_dw = 0;
    end
    if (owner == 2 && iREN) begin
      e_ren  = 1;
      e_addr = iaddr;
      if (ramstate == ACCESS) e_iw = 0;
    end
    chk({tag, ".ramREN"},   ramREN,   e_ren);
    chk({tag, ".ramWEN"},   ramWEN,   e_wen);
    chk({tag, ".ramaddr"},  ramaddr,  e_addr);
    chk({tag, ".ramstore"}, ramstore, e_store);
    chk({tag, ".iwait"},    iwait,    e_iw);
    chk({tag, ".dwait"},    dwait,    e_dw);
    chk({tag, ".iload"},    iload,    ramload);
    chk({tag, ".dload"},    dload,    ramload);
  endtask

  // One clock: check outputs mid-cycle, then advance the model across the edge.
  task automatic tick(input string tag);
    int nxt;
    bit ni;
    #1;
    check_outputs(tag);
    nxt = owner;
    ni  = iowed;
    case (owner)
      0: begin
        if (iowed && iREN)      nxt = 2;
        else if (dREN || dWEN)  nxt = 1;
        else if (iREN)          nxt = 2;
      end
      1: begin
        if (!(dREN || dWEN)) nxt = 0;
        else if (ramstate == ACCESS) begin
          nxt = 0;
          if (iREN) ni = 1;
        end
      end
      default: begin
        if (!iREN) nxt = 0;
        else if (ramstate == ACCESS) begin
          nxt = 0;
          ni  = 0;
        end
      end
    endcase
    @(posedge CLK);
    owner = nxt;
    iowed = ni;
    #1;
  endtask

  task automatic quiet();
    iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE;
  endtask

  logic [W-1:0] seen [8];
  logic [W-1:0] want [8];

  initial begin
    owner = 0; iowed = 0;
    nRST = 0;
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    #1;
    check_outputs("reset");
    @(posedge CLK);
    #1;
    nRST = 1;
    tick("idle0");

    // I-read alone, ACCESS on the third grant cycle.
    iREN = 1; iaddr = 32'h40; ramstate = FREE;
    tick("iread.idle");
    ramstate = BUSY;
    #1; chk("iread.c1.ramREN", ramREN, 1'b1); chk("iread.c1.ramaddr", ramaddr, 32'h40);
    tick("iread.c1");
    tick("iread.c2");
    ramstate = ACCESS; ramload = 32'hDEAD_BEEF;
    #1; chk("iread.c3.iwait", iwait, 1'b0); chk("iread.c3.iload", iload, 32'hDEAD_BEEF);
    chk("iread.c3.dwait", dwait, 1'b1);
    tick("iread.c3");
    quiet();
    #1; chk("iread.after.iwait", iwait, 1'b1);
    tick("iread.after");

    // Data write beats read and instruction; instruction served next.
    dWEN = 1; dREN = 1; daddr = 32'h100; dstore = 32'h1234_5678; iREN = 1; iaddr = 32'h80;
    tick("dwr.idle");
    ramstate = ACCESS;
    #1; chk("dwr.ramWEN", ramWEN, 1'b1); chk("dwr.ramREN", ramREN, 1'b0);
    chk("dwr.ramstore", ramstore, 32'h1234_5678); chk("dwr.ramaddr", ramaddr, 32'h100);
    tick("dwr.grant");
    ramstate = FREE;
    tick("dwr.gap");
    ramstate = ACCESS;
    #1; chk("dwr.next.ramaddr", ramaddr, 32'h80); chk("dwr.next.ramWEN", ramWEN, 1'b0);
    tick("dwr.igrant");
    quiet();
    tick("dwr.after");

    // Starvation guard: both sides always requesting, instant ACCESS.
    dREN = 1; iREN = 1; daddr = 32'h200; iaddr = 32'h300; ramstate = ACCESS;
    want[0] = 32'h0;   want[1] = 32'h200; want[2] = 32'h0; want[3] = 32'h300;
    want[4] = 32'h0;   want[5] = 32'h200; want[6] = 32'h0; want[7] = 32'h300;
    for (int i = 0; i < 8; i++) begin
      #1;
      seen[i] = (ramREN || ramWEN) ? ramaddr : '0;
      tick("starve");
    end
    for (int i = 0; i < 8; i++) chk($sformatf("starve.slot%0d", i), seen[i], want[i]);
    quiet();
    tick("starve.after");

    // Abort: dcache drops its read while RAM is busy.
    dREN = 1; daddr = 32'h44; ramstate = BUSY;
    tick("abort.idle");
    tick("abort.grant");
    dREN = 0;
    #1; chk("abort.ramREN", ramREN, 1'b0); chk("abort.dwait", dwait, 1'b1);
    tick("abort.drop");
    tick("abort.idle2");

    // Async reset in the middle of an instruction grant.
    iREN = 1; iaddr = 32'h88; ramstate = BUSY;
    tick("rst.idle");
    tick("rst.grant");
    #2;
    nRST = 0;
    #1;
    chk("rst.ramREN", ramREN, 1'b0); chk("rst.iwait", iwait, 1'b1);
    chk("rst.ramaddr", ramaddr, 32'h0);
    owner = 0; iowed = 0;
    @(posedge CLK);
    #1;
    nRST = 1;
    #1; chk("rst.release.ramREN", ramREN, 1'b0);
    tick("rst.reidle");
    ramstate = ACCESS;
    #1; chk("rst.regrant.ramREN", ramREN, 1'b1);
    tick("rst.regrant");
    quiet();
    tick("rst.after");

    // ERROR is held like BUSY for five cycles, then ACCESS completes.
    dREN = 1; daddr = 32'h3C;
    tick("err.idle");
    ramstate = ERROR;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("err.dwait", dwait, 1'b1); chk("err.ramREN", ramREN, 1'b1);
      chk("err.ramaddr", ramaddr, 32'h3C);
      tick("err.hold");
    end
    ramstate = ACCESS;
    #1; chk("err.done.dwait", dwait, 1'b0);
    tick("err.done");
    quiet();
    tick("err.after");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      iREN     = ($urandom_range(0, 3) != 0);
      dREN     = ($urandom_range(0, 2) == 0);
      dWEN     = ($urandom_range(0, 3) == 0);
      iaddr    = $urandom;
      daddr    = $urandom;
      dstore   = $urandom;
      ramload  = $urandom;
      ramstate = ramstate_t'($urandom_range(0, 3));
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
